hub75_fb_wr_arbiter: RTL
========================

// Module: hub75_fb_wr_arbiter
// PURPOSE
//  Double-buffered frame buffer write controller for the HUB75 display path.
//  Arbitrates round-robin between two pixel writers (req0, req1) onto the single
//  frame buffer write port. Steers all writes into the back page and swaps
//  front/back only at a display frame boundary, so the scanout never shows a
//  partially written frame. Sits between the pixel sources and the 2-page frame
//  buffer; o_front_page drives the display read page select.
// PARAMETERS
//  hpixel_p      64   display width in pixels
//  vpixel_p      64   display height in pixels
//  bpp_p         8    bits per colour channel
//  frame_size_p  --   localparam, hpixel_p*vpixel_p
//  addr_width_p  --   localparam, $clog2(frame_size_p)
// PORTS
//  clk            in   1               system clock
//  rst            in   1               async reset, active high
//  i_req0_valid   in   1               writer 0 has a pixel
//  o_req0_ready   out  1               writer 0 pixel accepted this cycle when valid&ready
//  i_req0_addr    in   addr_width_p    writer 0 pixel address, row-major
//  i_req0_data    in   3*bpp_p         writer 0 pixel {R,G,B}
//  i_req1_valid/o_req1_ready/i_req1_addr/i_req1_data   same for writer 1
//  i_swap_req     in   1               pulse: back page complete, request swap
//  i_frame_done   in   1               pulse from display: last row of frame latched
//  o_wr_en        out  1               frame buffer write strobe
//  o_wr_addr      out  addr_width_p+1  {page, pixel addr}; page = back page
//  o_wr_data      out  3*bpp_p         pixel {R,G,B}
//  o_front_page   out  1               page currently scanned out
//  o_swap_pending out  1               swap requested, awaiting i_frame_done
//  o_swap_done    out  1               1-cycle pulse when front page toggles
// BEHAVIOUR
//  Reset: state IDLE, o_front_page=0, last_grant=1, all other outputs 0;
//   o_wr_addr/o_wr_data=0. Reset mid-write drops the in-flight pixel.
//  FSM: IDLE -> PENDING on i_swap_req; PENDING -> IDLE on i_frame_done, with
//   o_front_page toggling and o_swap_done pulsing in the cycle after
//   i_frame_done is sampled. i_swap_req in PENDING is ignored (no queueing).
//   i_frame_done in IDLE is ignored.
//  o_swap_pending = (state==PENDING), registered.
//  Arbitration (combinational ready, IDLE only): only one valid -> it is
//   granted; both valid -> grant the requester not granted last; last_grant
//   updates only on an accepted handshake. First contention after reset goes
//   to req0. At most one ready high per cycle; ready never high without valid.
//  In PENDING both readies are 0 (back page frozen until swap). A handshake
//   in the same cycle as i_swap_req is accepted (FSM still IDLE that cycle).
//  Write latency: handshake at cycle t -> o_wr_en=1 at t+1 with the granted
//   addr/data registered and page = ~o_front_page sampled at t. Full
//   throughput: one pixel per cycle, back-to-back.
//  Address range: if addr >= frame_size_p the pixel is accepted (ready=1) but
//   o_wr_en stays 0 (dropped). No effect when frame_size_p is a power of 2.
//  o_wr_en=0 cycles: o_wr_addr/o_wr_data hold last value.
//  i_swap_req and i_frame_done in the same IDLE cycle: enter PENDING, swap
//   waits for the next i_frame_done (no same-cycle swap).
// TESTING
//  1. Reset, req0 valid addr=5 data=0xFF0000 -> ready0=1; next cycle
//     o_wr_en=1, o_wr_addr={1'b1,12'd5}, o_wr_data=0xFF0000.
//  2. req0 and req1 valid continuously for 6 cycles -> grants 0,1,0,1,0,1;
//     o_wr_en high 6 consecutive cycles, one cycle delayed.
//  3. i_swap_req pulse, writers valid -> readies 0 from next cycle,
//     o_swap_pending=1; i_frame_done 10 cycles later -> o_front_page 0->1,
//     o_swap_done 1 cycle, readies resume; next write uses page bit 0.
//  4. i_swap_req and i_frame_done same cycle -> no swap; swap only on the
//     following i_frame_done pulse.
//  5. Second i_swap_req while PENDING, and i_frame_done while IDLE -> no
//     state change, o_front_page unchanged.
//  6. Assert rst during PENDING with handshake in flight -> outputs 0,
//     o_front_page=0, no o_wr_en after release until a new handshake.

Source files
------------

// File: rtl/hub75_fb_wr_if.sv
// Pixel-writer handshakes and frame buffer write port of the HUB75 frame buffer write arbiter.
// Valid/ready: a pixel transfers on any clock edge where valid and ready are both high; ready depends combinationally on valid.
interface hub75_fb_wr_if #(
  parameter int addr_width_p = 12,
  parameter int data_width_p = 24
);
  logic                    i_req0_valid;
  logic                    o_req0_ready;
  logic [addr_width_p-1:0] i_req0_addr;
  logic [data_width_p-1:0] i_req0_data;
  logic                    i_req1_valid;
  logic                    o_req1_ready;
  logic [addr_width_p-1:0] i_req1_addr;
  logic [data_width_p-1:0] i_req1_data;
  logic                    o_wr_en;
  logic [addr_width_p:0]   o_wr_addr;
  logic [data_width_p-1:0] o_wr_data;

  modport slave (
    input  i_req0_valid, i_req0_addr, i_req0_data,
    input  i_req1_valid, i_req1_addr, i_req1_data,
    output o_req0_ready, o_req1_ready,
    output o_wr_en, o_wr_addr, o_wr_data
  );

  modport master (
    output i_req0_valid, i_req0_addr, i_req0_data,
    output i_req1_valid, i_req1_addr, i_req1_data,
    input  o_req0_ready, o_req1_ready,
    input  o_wr_en, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/hub75_fb_wr_arbiter.sv
// Round-robin arbiter of two pixel writers onto the back page of a 2-page frame buffer;
// front/back pages swap only on a display frame boundary after a swap request.
module hub75_fb_wr_arbiter #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p    = 8
) (
  input  logic                clk,
  input  logic                rst,
  hub75_fb_wr_if.slave        bus,
  input  logic                i_swap_req,
  input  logic                i_frame_done,
  output logic                o_front_page,
  output logic                o_swap_pending,
  output logic                o_swap_done,
  output logic                o_dbg_state
);
  localparam int unsigned frame_size_p = hpixel_p * vpixel_p;
  localparam int          addr_width_p = $clog2(frame_size_p);
  localparam int          data_width_p = 3 * bpp_p;

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic                    front_page_q, front_page_d;
  logic                    last_grant_q, last_grant_d;
  logic                    swap_done_q, swap_done_d;
  logic                    wr_en_q, wr_en_d;
  logic [addr_width_p:0]   wr_addr_q, wr_addr_d;
  logic [data_width_p-1:0] wr_data_q, wr_data_d;

  logic                    idle;
  logic                    grant0, grant1;
  logic [addr_width_p-1:0] sel_addr;
  logic [data_width_p-1:0] sel_data;

  always_comb begin
    idle     = (state_q == IDLE);
    // last_grant_q==1 means writer 1 won last, so writer 0 wins the next tie.
    grant0   = idle && bus.i_req0_valid && (!bus.i_req1_valid || last_grant_q);
    grant1   = idle && bus.i_req1_valid && (!bus.i_req0_valid || !last_grant_q);
    sel_addr = grant1 ? bus.i_req1_addr : bus.i_req0_addr;
    sel_data = grant1 ? bus.i_req1_data : bus.i_req0_data;

    state_d      = state_q;
    front_page_d = front_page_q;
    last_grant_d = last_grant_q;
    swap_done_d  = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (grant0 || grant1) begin
      last_grant_d = grant1;
      // Out-of-range pixels are consumed but never written.
      if (32'(sel_addr) < frame_size_p) begin
        wr_en_d   = 1'b1;
        wr_addr_d = {~front_page_q, sel_addr};
        wr_data_d = sel_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (i_swap_req) state_d = PENDING;
      end
      PENDING: begin
        if (i_frame_done) begin
          state_d      = IDLE;
          front_page_d = ~front_page_q;
          swap_done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      front_page_q <= 1'b0;
      last_grant_q <= 1'b1;
      swap_done_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      front_page_q <= front_page_d;
      last_grant_q <= last_grant_d;
      swap_done_q  <= swap_done_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.o_req0_ready = grant0;
  assign bus.o_req1_ready = grant1;
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign o_front_page     = front_page_q;
  assign o_swap_pending   = (state_q == PENDING);
  assign o_swap_done      = swap_done_q;
  assign o_dbg_state      = state_q;
endmodule
